pipe_mem_arbiter: RTL and testbench

- Shares one single-ported backing memory between the pipeline's IF stage (instruction fetch, read-only) and MEM stage (load/store).
- Replaces the separate instruction and data memories with a unified memory bus.
- Sequences each access with a request/acknowledge handshake and raises a pipeline-wide stall while any stage waits.
- Aborts bus accesses that exceed a timeout.

---
 rtl/pipe_mem_arbiter.sv | 133 +++++++++++++
 tb/tb_pipe_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter: shares one single-ported backing memory between the IF and MEM pipeline stages.
// Define ARB_FAIR_EN to bound consecutive MEM grants (MAX_STREAK) while IF waits.
module pipe_mem_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int TIMEOUT    = 255,
   parameter int MAX_STREAK = 4
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          if_req_i,
   input  logic [AW-1:0] if_addr_i,
   output logic [DW-1:0] if_rdata_o,
   output logic          if_done_o,
   input  logic          mem_req_i,
   input  logic          mem_we_i,
   input  logic [AW-1:0] mem_addr_i,
   input  logic [DW-1:0] mem_wdata_i,
   output logic [DW-1:0] mem_rdata_o,
   output logic          mem_done_o,
   output logic          bus_req_o,
   output logic          bus_we_o,
   output logic [AW-1:0] bus_addr_o,
   output logic [DW-1:0] bus_wdata_o,
   input  logic          bus_ack_i,
   input  logic [DW-1:0] bus_rdata_i,
   output logic          stall_o,
   output logic          err_o
);

   typedef enum logic [1:0] {IDLE, BUS_IF, BUS_MEM, RESP} state_t;

   localparam int            CW      = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] T_LIMIT = CW'(TIMEOUT - 1);

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("pipe_mem_arbiter: TIMEOUT must be >= 1");
   end
   if (MAX_STREAK < 1) begin : g_bad_streak
      $error("pipe_mem_arbiter: MAX_STREAK must be >= 1");
   end

   state_t        state;
   logic [CW-1:0] tmo_cnt;
   logic          any_req;
   logic          if_wins;
   logic          bus_done;

   assign any_req  = if_req_i | mem_req_i;
   assign bus_done = bus_ack_i | (tmo_cnt == T_LIMIT);

`ifdef ARB_FAIR_EN
   localparam int SW = $clog2(MAX_STREAK + 1);
   logic [SW-1:0] streak;

   assign if_wins = if_req_i & (~mem_req_i | (streak == SW'(MAX_STREAK)));

   // Streak counts MEM grants that left IF waiting; any IF grant or idle IF restarts it.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         streak <= '0;
      end else if (state == IDLE && any_req) begin
         if (if_wins || !if_req_i) streak <= '0;
         else                      streak <= streak + 1'b1;
      end
   end
`else
   assign if_wins = if_req_i & ~mem_req_i;
`endif

   assign stall_o = (if_req_i & ~if_done_o) | (mem_req_i & ~mem_done_o);

   // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state       <= IDLE;
         tmo_cnt     <= '0;
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_wdata_o <= '0;
         if_done_o   <= 1'b0;
         mem_done_o  <= 1'b0;
         if_rdata_o  <= '0;
         mem_rdata_o <= '0;
         err_o       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  bus_req_o <= 1'b1;
                  tmo_cnt   <= '0;
                  if (if_wins) begin
                     state       <= BUS_IF;
                     bus_we_o    <= 1'b0;
                     bus_addr_o  <= if_addr_i;
                     bus_wdata_o <= '0;
                  end else begin
                     state       <= BUS_MEM;
                     bus_we_o    <= mem_we_i;
                     bus_addr_o  <= mem_addr_i;
                     bus_wdata_o <= mem_wdata_i;
                  end
               end
            end
            BUS_IF, BUS_MEM: begin
               if (bus_done) begin
                  // An ack on the limit cycle still wins; all-ones marks an aborted access.
                  bus_req_o <= 1'b0;
                  state     <= RESP;
                  if (!bus_ack_i) err_o <= 1'b1;
                  if (state == BUS_IF) begin
                     if_done_o  <= 1'b1;
                     if_rdata_o <= bus_ack_i ? bus_rdata_i : '1;
                  end else begin
                     mem_done_o  <= 1'b1;
                     mem_rdata_o <= bus_ack_i ? bus_rdata_i : '1;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            RESP: begin
               if_done_o  <= 1'b0;
               mem_done_o <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed self-checking bench for pipe_mem_arbiter (TIMEOUT=4); honours ARB_FAIR_EN when defined.
module tb_pipe_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk_i = 1'b0;
   logic          rst_n_i;
   logic          if_req_i;
   logic [AW-1:0] if_addr_i;
   logic [DW-1:0] if_rdata_o;
   logic          if_done_o;
   logic          mem_req_i;
   logic          mem_we_i;
   logic [AW-1:0] mem_addr_i;
   logic [DW-1:0] mem_wdata_i;
   logic [DW-1:0] mem_rdata_o;
   logic          mem_done_o;
   logic          bus_req_o;
   logic          bus_we_o;
   logic [AW-1:0] bus_addr_o;
   logic [DW-1:0] bus_wdata_o;
   logic          bus_ack_i;
   logic [DW-1:0] bus_rdata_i;
   logic          stall_o;
   logic          err_o;

   int checks   = 0;
   int failures = 0;

   pipe_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4), .MAX_STREAK(4)) dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .if_req_i    (if_req_i),
      .if_addr_i   (if_addr_i),
      .if_rdata_o  (if_rdata_o),
      .if_done_o   (if_done_o),
      .mem_req_i   (mem_req_i),
      .mem_we_i    (mem_we_i),
      .mem_addr_i  (mem_addr_i),
      .mem_wdata_i (mem_wdata_i),
      .mem_rdata_o (mem_rdata_o),
      .mem_done_o  (mem_done_o),
      .bus_req_o   (bus_req_o),
      .bus_we_o    (bus_we_o),
      .bus_addr_o  (bus_addr_o),
      .bus_wdata_o (bus_wdata_o),
      .bus_ack_i   (bus_ack_i),
      .bus_rdata_i (bus_rdata_i),
      .stall_o     (stall_o),
      .err_o       (err_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Advance one cycle; outputs are then stable and inputs set here are sampled at the next edge.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      int            grants;
      logic [AW-1:0] exp_addr;

      rst_n_i     = 1'b0;
      if_req_i    = 1'b0;
      if_addr_i   = '0;
      mem_req_i   = 1'b0;
      mem_we_i    = 1'b0;
      mem_addr_i  = '0;
      mem_wdata_i = '0;
      bus_ack_i   = 1'b0;
      bus_rdata_i = '0;

      // Reset state
      step();
      step();
      check("rst_bus_req", bus_req_o, 0);
      check("rst_bus_we", bus_we_o, 0);
      check("rst_bus_addr", bus_addr_o, 0);
      check("rst_bus_wdata", bus_wdata_o, 0);
      check("rst_if_done", if_done_o, 0);
      check("rst_mem_done", mem_done_o, 0);
      check("rst_if_rdata", if_rdata_o, 0);
      check("rst_mem_rdata", mem_rdata_o, 0);
      check("rst_err", err_o, 0);
      check("rst_stall", stall_o, 0);
      rst_n_i = 1'b1;
      step();

      // IF only, zero-wait slave
      step();                                   // cycle 0
      if_req_i  = 1'b1;
      if_addr_i = 32'h10;
      #1;
      check("t1_c0_stall", stall_o, 1);
      check("t1_c0_bus_req", bus_req_o, 0);
      step();                                   // cycle 1
      check("t1_c1_bus_req", bus_req_o, 1);
      check("t1_c1_bus_addr", bus_addr_o, 32'h10);
      check("t1_c1_bus_we", bus_we_o, 0);
      check("t1_c1_stall", stall_o, 1);
      check("t1_c1_if_done", if_done_o, 0);
      bus_ack_i   = 1'b1;
      bus_rdata_i = 32'h8C220004;
      step();                                   // cycle 2
      bus_ack_i = 1'b0;
      check("t1_c2_bus_req", bus_req_o, 0);
      check("t1_c2_if_done", if_done_o, 1);
      check("t1_c2_if_rdata", if_rdata_o, 32'h8C220004);
      check("t1_c2_stall", stall_o, 0);
      check("t1_c2_err", err_o, 0);
      if_req_i = 1'b0;
      step();                                   // cycle 3
      check("t1_c3_if_done", if_done_o, 0);
      check("t1_c3_bus_req", bus_req_o, 0);

      // Simultaneous IF and MEM store; MEM ack lands exactly on the timeout limit cycle
      step();                                   // cycle 0
      if_req_i    = 1'b1;
      if_addr_i   = 32'h20;
      mem_req_i   = 1'b1;
      mem_we_i    = 1'b1;
      mem_addr_i  = 32'h100;
      mem_wdata_i = 32'hDEADBEEF;
      step();                                   // cycle 1
      check("t2_c1_bus_req", bus_req_o, 1);
      check("t2_c1_bus_we", bus_we_o, 1);
      check("t2_c1_bus_addr", bus_addr_o, 32'h100);
      check("t2_c1_bus_wdata", bus_wdata_o, 32'hDEADBEEF);
      check("t2_c1_stall", stall_o, 1);
      for (int c = 2; c <= 4; c++) begin
         step();                                // cycles 2..4
         check($sformatf("t2_c%0d_bus_req", c), bus_req_o, 1);
         check($sformatf("t2_c%0d_bus_addr", c), bus_addr_o, 32'h100);
      end
      bus_ack_i   = 1'b1;
      bus_rdata_i = 32'h12345678;
      step();                                   // cycle 5
      bus_ack_i = 1'b0;
      check("t2_c5_mem_done", mem_done_o, 1);
      check("t2_c5_if_done", if_done_o, 0);
      check("t2_c5_bus_req", bus_req_o, 0);
      check("t2_c5_err", err_o, 0);
      check("t2_c5_stall", stall_o, 1);
      mem_req_i = 1'b0;
      mem_we_i  = 1'b0;
      step();                                   // cycle 6
      check("t2_c6_mem_done", mem_done_o, 0);
      check("t2_c6_bus_req", bus_req_o, 0);
      step();                                   // cycle 7
      check("t2_c7_bus_req", bus_req_o, 1);
      check("t2_c7_bus_addr", bus_addr_o, 32'h20);
      check("t2_c7_bus_we", bus_we_o, 0);
      check("t2_c7_bus_wdata", bus_wdata_o, 0);
      step();                                   // cycle 8
      check("t2_c8_if_done", if_done_o, 0);
      bus_ack_i   = 1'b1;
      bus_rdata_i = 32'h00000013;
      step();                                   // cycle 9
      bus_ack_i = 1'b0;
      check("t2_c9_if_done", if_done_o, 1);
      check("t2_c9_if_rdata", if_rdata_o, 32'h00000013);
      check("t2_c9_mem_done", mem_done_o, 0);
      if_req_i = 1'b0;
      step();                                   // cycle 10
      check("t2_c10_if_done", if_done_o, 0);

      // MEM load with no ack: abort after exactly TIMEOUT=4 bus cycles
      step();                                   // cycle 0
      mem_req_i  = 1'b1;
      mem_we_i   = 1'b0;
      mem_addr_i = 32'h104;
      for (int c = 1; c <= 4; c++) begin
         step();                                // cycles 1..4
         check($sformatf("t3_c%0d_bus_req", c), bus_req_o, 1);
         check($sformatf("t3_c%0d_mem_done", c), mem_done_o, 0);
      end
      check("t3_c4_bus_addr", bus_addr_o, 32'h104);
      check("t3_c4_err", err_o, 0);
      step();                                   // cycle 5
      check("t3_c5_bus_req", bus_req_o, 0);
      check("t3_c5_mem_done", mem_done_o, 1);
      check("t3_c5_mem_rdata", mem_rdata_o, 32'hFFFFFFFF);
      check("t3_c5_err", err_o, 1);
      mem_req_i = 1'b0;
      step();                                   // cycle 6
      check("t3_c6_mem_done", mem_done_o, 0);
      check("t3_c6_err_sticky", err_o, 1);
      step();
      check("t3_c7_err_sticky", err_o, 1);

      // Reset while in BUS_MEM, then a late ack
      step();                                   // cycle 0
      mem_req_i   = 1'b1;
      mem_we_i    = 1'b1;
      mem_addr_i  = 32'h200;
      mem_wdata_i = 32'h0000A5A5;
      step();                                   // cycle 1
      check("t4_c1_bus_req", bus_req_o, 1);
      rst_n_i = 1'b0;
      step();                                   // cycle 2
      check("t4_c2_bus_req", bus_req_o, 0);
      check("t4_c2_mem_done", mem_done_o, 0);
      check("t4_c2_err", err_o, 0);
      rst_n_i     = 1'b1;
      mem_req_i   = 1'b0;
      mem_we_i    = 1'b0;
      bus_ack_i   = 1'b1;
      bus_rdata_i = 32'hCAFEF00D;
      step();                                   // cycle 3
      bus_ack_i = 1'b0;
      check("t4_c3_mem_done", mem_done_o, 0);
      check("t4_c3_bus_req", bus_req_o, 0);
      check("t4_c3_mem_rdata", mem_rdata_o, 0);
      step();                                   // cycle 4
      check("t4_c4_mem_done", mem_done_o, 0);
      check("t4_c4_if_done", if_done_o, 0);

      // Both requesters continuously pending, zero-wait slave
      if_req_i   = 1'b1;
      if_addr_i  = 32'h40;
      mem_req_i  = 1'b1;
      mem_we_i   = 1'b0;
      mem_addr_i = 32'h300;
      grants     = 0;
      for (int c = 0; c < 40 && grants < 10; c++) begin
         step();
         if (bus_req_o) begin
`ifdef ARB_FAIR_EN
            exp_addr = ((grants % 5) == 4) ? 32'h40 : 32'h300;
`else
            exp_addr = 32'h300;
`endif
            check($sformatf("t5_grant%0d_addr", grants), bus_addr_o, exp_addr);
            grants++;
            bus_ack_i   = 1'b1;
            bus_rdata_i = 32'h1000 + 32'(grants);
         end else begin
            bus_ack_i = 1'b0;
         end
      end
      check("t5_grant_count", grants, 10);
      bus_ack_i = 1'b0;
      if_req_i  = 1'b0;
      mem_req_i = 1'b0;
      step();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
